mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester controller for the single-port instruction/data memory. Sits between the fetch stage (instruction port, read-only) and the load/store stage (data port, read/write) and the `memory` instance. Each cycle it grants at most one request using round-robin arbitration, drives the memory port, and routes the one-cycle-latency read data back to the owner. Out-of-range addresses are rejected locally with an error response and never reach the memory.

## Interface
Parameters:
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width
- `BASE_ADDR`, 32'h01000000, first valid byte address
- `MEM_BYTES`, 32'h00100000, size of the valid window in bytes

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req_valid_i`  in  1  instruction read request
- `i_addr_i`  in  AWIDTH  instruction address
- `i_req_ready_o`  out  1  instruction request accepted this cycle
- `i_rsp_valid_o`  out  1  instruction response valid
- `i_rdata_o`  out  DWIDTH  instruction read data
- `i_rsp_err_o`  out  1  instruction address out of range
- `d_req_valid_i`  in  1  data request
- `d_we_i`  in  1  1 = store, 0 = load
- `d_addr_i`  in  AWIDTH  data address
- `d_wdata_i`  in  DWIDTH  store data
- `d_req_ready_o`  out  1  data request accepted this cycle
- `d_rsp_valid_o`  out  1  data response valid (load data or store acknowledge)
- `d_rdata_o`  out  DWIDTH  load data
- `d_rsp_err_o`  out  1  data address out of range
- `mem_addr_o`  out  AWIDTH  memory address
- `mem_data_o`  out  DWIDTH  memory write data
- `mem_read_en_o`  out  1  memory read strobe
- `mem_write_en_o`  out  1  memory write strobe
- `mem_data_i`  in  DWIDTH  memory read data, valid one cycle after `mem_read_en_o`

## Operation
- Acceptance: a request is accepted in cycle N when `valid & ready` are both high. Readies are combinational from the valids and the `last_grant` register, and are never both high.
- Grant rules:
  - Only one valid: grant it.
  - Both valid: grant the port opposite `last_grant`.
  - `last_grant` updates only on an accepted request.
  - Reset value of `last_grant` is DATA, so the first contended cycle goes to the instruction port.
- Range check: in range ⇔ `BASE_ADDR <= addr < BASE_ADDR + MEM_BYTES`.
  - Compute in AWIDTH+1 bits so the window end does not wrap.
  - Addresses are not realigned.
- Accepted and in range:
  - `mem_addr_o` = addr.
  - Load/fetch: `mem_read_en_o` = 1.
  - Store: `mem_write_en_o` = 1, `mem_data_o` = wdata.
- Accepted and out of range: both memory enables stay 0. The error flag is recorded.
- Idle defaults: memory enables 0, `mem_addr_o`/`mem_data_o` = 0.
- Response register: holds `rsp_pending`, owner, error, and is_store. It is written every cycle from the grant result.
- Response in cycle N+1 to the owner only:
  - `*_rsp_valid_o` = 1.
  - `*_rdata_o` = `mem_data_i` for in-range reads; 0 for stores and errors.
  - `*_rsp_err_o` = error flag.
- The non-owner's response outputs are all 0.
- Responses have no backpressure; requesters must consume them on the cycle they are valid.
- Requests may be accepted back-to-back. A new grant in N+1 coexists with the response to N.

## Timing
- Request-to-response latency is exactly 1 cycle for all outcomes. Throughput is 1 request per cycle.
- Reset values (`rst` high at an edge), effective the following cycle:
  - All `*_rsp_valid_o`, `*_rsp_err_o`, `*_rdata_o` = 0.
  - `rsp_pending` = 0.
  - `last_grant` = DATA.
- While `rst` is high:
  - Both readies are forced to 0.
  - Memory enables are forced to 0.
  - No request is accepted.
- Reset mid-operation: a response pending when `rst` asserts is dropped, not delivered. A store accepted in the cycle before reset has already been written.
- Simultaneous valids every cycle give strict I, D, I, D alternation.
- A single requester holding valid continuously is granted every cycle.
- Boundary addresses:
  - `BASE_ADDR + MEM_BYTES - 1`: in range.
  - `BASE_ADDR + MEM_BYTES`: error.
  - `BASE_ADDR - 1`: error.
  - 32'hFFFFFFFF: error, with no wrap.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {OWN_I, OWN_D} owner_e`.
  - Response-register struct `rsp_slot_t` with fields `pending`, `owner`, `err`, `is_store`.
  - Default localparams `MEM_BASE_ADDR` and `MEM_SIZE_BYTES`.
- Sub-module `rr_arbiter2`:
  - Purely combinational grant from two valids plus a last-grant input.
  - Reusable elsewhere.
  - The `last_grant` flop stays in `mem_arbiter`.

## Test plan
- Reset: hold `rst` for 3 cycles with both valids high. Required: both readies 0, memory enables 0, responses 0. The first cycle after reset grants I.
- Fetch stream: I valid continuously from 0x01000000 with incrementing addresses. Required: ready every cycle, `i_rsp_valid_o` every cycle from the second accepted request on, `i_rdata_o` matching the memory preload.
- Contention: both valid for 4 cycles, D store of 0xDEADBEEF to 0x01000010. Required: grant order I, D, I, D; the store acknowledge arrives with `d_rdata_o` = 0; a later load of 0x01000010 returns 0xDEADBEEF.
- Range error: D load at 0x01100000, then I fetch at 0x00FFFFFC. Required: error response 1 cycle later with rdata 0 and no memory enable asserted. A load at 0x010FFFFC succeeds.
- Reset mid-op: accept a D load, assert `rst` on the next edge. Required: no `d_rsp_valid_o` is delivered and `last_grant` returns to DATA.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default memory window for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Which requester owns a grant or an in-flight response.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // One-deep response slot: what the memory returns next cycle and to whom.
    typedef struct packed {
        logic   pending;
        owner_e owner;
        logic   err;
        logic   is_store;
    } rsp_slot_t;

    localparam int unsigned MEM_BASE_ADDR  = 32'h0100_0000;
    localparam int unsigned MEM_SIZE_BYTES = 32'h0010_0000;

    localparam rsp_slot_t RSP_SLOT_IDLE = '{
        pending:  1'b0,
        owner:    OWN_D,
        err:      1'b0,
        is_store: 1'b0
    };

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; purely combinational, the caller owns the last-grant state.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   i_valid,
    input  logic   d_valid,
    input  owner_e last_grant,
    output logic   i_grant,
    output logic   d_grant
);

    // Lone requester always wins; on contention the side not served last wins.
    always_comb begin
        i_grant = 1'b0;
        d_grant = 1'b0;
        if (i_valid && d_valid) begin
            if (last_grant == OWN_D) begin
                i_grant = 1'b1;
            end else begin
                d_grant = 1'b1;
            end
        end else begin
            i_grant = i_valid;
            d_grant = d_valid;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end for the single-port instruction/data memory with local range check.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AWIDTH    = 32,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned BASE_ADDR = MEM_BASE_ADDR,
    parameter int unsigned MEM_BYTES = MEM_SIZE_BYTES
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid_i,
    input  logic [AWIDTH-1:0] i_addr_i,
    output logic              i_req_ready_o,
    output logic              i_rsp_valid_o,
    output logic [DWIDTH-1:0] i_rdata_o,
    output logic              i_rsp_err_o,

    input  logic              d_req_valid_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_req_ready_o,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic              d_rsp_err_o,

    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    // One extra bit so BASE_ADDR + MEM_BYTES cannot wrap back into the window.
    localparam int unsigned EW = AWIDTH + 1;
    localparam logic [EW-1:0] WIN_LO = EW'(BASE_ADDR);
    localparam logic [EW-1:0] WIN_HI = WIN_LO + EW'(MEM_BYTES);

    owner_e            last_grant;
    rsp_slot_t         rsp_slot;
    rsp_slot_t         rsp_slot_next;

    logic              i_grant;
    logic              d_grant;

    logic              accept;
    owner_e            sel_owner;
    logic [AWIDTH-1:0] sel_addr;
    logic              sel_store;
    logic [DWIDTH-1:0] sel_wdata;
    logic              sel_in_range;

    logic              rsp_live;
    logic [DWIDTH-1:0] rsp_data;

    rr_arbiter2 u_rr (
        .i_valid    (i_req_valid_i),
        .d_valid    (d_req_valid_i),
        .last_grant (last_grant),
        .i_grant    (i_grant),
        .d_grant    (d_grant)
    );

    // Readies and the selected request; reset blocks all acceptance.
    always_comb begin
        i_req_ready_o = 1'b0;
        d_req_ready_o = 1'b0;
        accept        = 1'b0;
        sel_owner     = OWN_I;
        sel_addr      = '0;
        sel_store     = 1'b0;
        sel_wdata     = '0;
        if (!rst) begin
            if (i_grant) begin
                i_req_ready_o = 1'b1;
                accept        = 1'b1;
                sel_owner     = OWN_I;
                sel_addr      = i_addr_i;
            end else if (d_grant) begin
                d_req_ready_o = 1'b1;
                accept        = 1'b1;
                sel_owner     = OWN_D;
                sel_addr      = d_addr_i;
                sel_store     = d_we_i;
                sel_wdata     = d_wdata_i;
            end
        end
    end

    // Window check on the selected address, without realignment.
    always_comb begin
        sel_in_range = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);
    end

    // Memory port: only accepted, in-range requests ever reach the memory.
    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (accept && sel_in_range) begin
            mem_addr_o = sel_addr;
            if (sel_store) begin
                mem_write_en_o = 1'b1;
                mem_data_o     = sel_wdata;
            end else begin
                mem_read_en_o = 1'b1;
            end
        end
    end

    // Next response slot, rewritten every cycle from this cycle's grant.
    always_comb begin
        rsp_slot_next          = RSP_SLOT_IDLE;
        rsp_slot_next.pending  = accept;
        rsp_slot_next.owner    = sel_owner;
        rsp_slot_next.err      = accept && !sel_in_range;
        rsp_slot_next.is_store = accept && sel_store;
    end

    // Round-robin history and the one-cycle response slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_D;
            rsp_slot   <= RSP_SLOT_IDLE;
        end else begin
            rsp_slot <= rsp_slot_next;
            if (accept) begin
                last_grant <= sel_owner;
            end
        end
    end

    // Route the response to its owner only; reset drops anything in flight.
    always_comb begin
        rsp_live      = rsp_slot.pending && !rst;
        rsp_data      = (rsp_slot.err || rsp_slot.is_store) ? '0 : mem_data_i;

        i_rsp_valid_o = 1'b0;
        i_rdata_o     = '0;
        i_rsp_err_o   = 1'b0;
        d_rsp_valid_o = 1'b0;
        d_rdata_o     = '0;
        d_rsp_err_o   = 1'b0;

        if (rsp_live) begin
            if (rsp_slot.owner == OWN_I) begin
                i_rsp_valid_o = 1'b1;
                i_rdata_o     = rsp_data;
                i_rsp_err_o   = rsp_slot.err;
            end else begin
                d_rsp_valid_o = 1'b1;
                d_rdata_o     = rsp_data;
                d_rsp_err_o   = rsp_slot.err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, queued expectations, independent response monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        i_req_valid_i;
    logic [31:0] i_addr_i;
    logic        i_req_ready_o;
    logic        i_rsp_valid_o;
    logic [31:0] i_rdata_o;
    logic        i_rsp_err_o;

    logic        d_req_valid_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_req_ready_o;
    logic        d_rsp_valid_o;
    logic [31:0] d_rdata_o;
    logic        d_rsp_err_o;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i = 32'h0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        owner;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_arr[int unsigned];
    logic [31:0] shadow[int unsigned];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid_i  (i_req_valid_i),
        .i_addr_i       (i_addr_i),
        .i_req_ready_o  (i_req_ready_o),
        .i_rsp_valid_o  (i_rsp_valid_o),
        .i_rdata_o      (i_rdata_o),
        .i_rsp_err_o    (i_rsp_err_o),
        .d_req_valid_i  (d_req_valid_i),
        .d_we_i         (d_we_i),
        .d_addr_i       (d_addr_i),
        .d_wdata_i      (d_wdata_i),
        .d_req_ready_o  (d_req_ready_o),
        .d_rsp_valid_o  (d_rsp_valid_o),
        .d_rdata_o      (d_rdata_o),
        .d_rsp_err_o    (d_rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_data_i     (mem_data_i)
    );

    function automatic logic [31:0] preload(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write_en_o) mem_arr[mem_addr_o] = mem_data_o;
        if (mem_read_en_o)
            mem_data_i <= mem_arr.exists(mem_addr_o) ? mem_arr[mem_addr_o] : preload(mem_addr_o);
        else
            mem_data_i <= 32'h0BAD_0BAD;
    end

    // Response monitor: every cycle either the queued response or silence.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("rsp_missing", 32'(cyc), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            if (e.owner == 1'b0) begin
                chk("i_rsp_valid", 32'(i_rsp_valid_o), 32'(1));
                chk("i_rdata", i_rdata_o, e.data);
                chk("i_rsp_err", 32'(i_rsp_err_o), 32'(e.err));
                chk("d_rsp_quiet", 32'({d_rsp_valid_o, d_rsp_err_o}) | d_rdata_o, 32'(0));
            end else begin
                chk("d_rsp_valid", 32'(d_rsp_valid_o), 32'(1));
                chk("d_rdata", d_rdata_o, e.data);
                chk("d_rsp_err", 32'(d_rsp_err_o), 32'(e.err));
                chk("i_rsp_quiet", 32'({i_rsp_valid_o, i_rsp_err_o}) | i_rdata_o, 32'(0));
            end
        end else begin
            chk("rsp_idle", 32'({i_rsp_valid_o, d_rsp_valid_o}), 32'(0));
        end
    end

    // One cycle of stimulus; exp_g: 0 none, 1 instruction, 2 data.
    task automatic step(input logic r,
                        input logic iv, input logic [31:0] ia,
                        input logic dv, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                        input int exp_g, input logic exp_err, input logic exp_rsp);
        logic [31:0] addr;
        logic [31:0] data;
        logic        store;
        logic        exp_rd;
        logic        exp_wr;
        exp_t        e;
        rst           = r;
        i_req_valid_i = iv;
        i_addr_i      = ia;
        d_req_valid_i = dv;
        d_we_i        = dwe;
        d_addr_i      = da;
        d_wdata_i     = dwd;
        @(negedge clk);
        addr  = (exp_g == 1) ? ia : da;
        store = (exp_g == 2) && dwe;
        exp_rd = (exp_g != 0) && !exp_err && !store;
        exp_wr = (exp_g != 0) && !exp_err && store;
        chk("i_ready", 32'(i_req_ready_o), 32'(exp_g == 1));
        chk("d_ready", 32'(d_req_ready_o), 32'(exp_g == 2));
        chk("mem_read_en", 32'(mem_read_en_o), 32'(exp_rd));
        chk("mem_write_en", 32'(mem_write_en_o), 32'(exp_wr));
        if (exp_rd || exp_wr) chk("mem_addr", mem_addr_o, addr);
        if (exp_wr) chk("mem_data", mem_data_o, dwd);
        if (r) begin
            chk("rst_rsp_flags", 32'({i_rsp_valid_o, i_rsp_err_o, d_rsp_valid_o, d_rsp_err_o}), 32'(0));
            chk("rst_rsp_data", i_rdata_o | d_rdata_o, 32'(0));
        end
        if (exp_g != 0) begin
            if (exp_err || store)
                data = 32'h0;
            else
                data = shadow.exists(addr) ? shadow[addr] : preload(addr);
            if (exp_wr) shadow[addr] = dwd;
            if (exp_rsp) begin
                e.cyc   = cyc + 1;
                e.owner = (exp_g == 2);
                e.err   = exp_err;
                e.data  = data;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_req_valid_i = 1'b0; i_addr_i = '0;
        d_req_valid_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        @(posedge clk);
        #1;

        // Reset held with both requesters asking.
        for (int k = 0; k < 3; k++)
            step(1, 1, 32'h0100_0000, 1, 0, 32'h0100_0100, 0, 0, 0, 0);

        // First contended cycle after reset goes to I.
        step(0, 1, 32'h0100_0000, 1, 0, 32'h0100_0100, 0, 1, 0, 1);

        // Fetch stream.
        for (int k = 1; k <= 5; k++)
            step(0, 1, 32'h0100_0000 + 32'(k * 4), 0, 0, 0, 0, 1, 0, 1);

        // Lone data load, leaving last grant on D.
        step(0, 0, 0, 1, 0, 32'h0100_0008, 0, 2, 0, 1);

        // Contention: I, D(store), I, D(load of stored word), then I alone.
        step(0, 1, 32'h0100_0020, 1, 1, 32'h0100_0010, 32'hDEAD_BEEF, 1, 0, 1);
        step(0, 1, 32'h0100_0024, 1, 1, 32'h0100_0010, 32'hDEAD_BEEF, 2, 0, 1);
        step(0, 1, 32'h0100_0024, 1, 0, 32'h0100_0010, 0, 1, 0, 1);
        step(0, 1, 32'h0100_0028, 1, 0, 32'h0100_0010, 0, 2, 0, 1);
        step(0, 1, 32'h0100_0028, 0, 0, 0, 0, 1, 0, 1);

        // Window boundaries.
        step(0, 0, 0, 1, 0, 32'h0110_0000, 0, 2, 1, 1);
        step(0, 1, 32'h00FF_FFFC, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 32'h010F_FFFC, 0, 2, 0, 1);
        step(0, 1, 32'h010F_FFFF, 0, 0, 0, 0, 1, 0, 1);
        step(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 32'h00FF_FFFF, 0, 2, 1, 1);
        step(0, 0, 0, 1, 1, 32'h0110_0000, 32'h1234_5678, 2, 1, 1);
        step(0, 1, 32'h0000_0000, 1, 0, 32'h0100_0040, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset right after an accepted D load drops its response.
        step(0, 0, 0, 1, 0, 32'h0100_0000, 0, 2, 0, 0);
        step(1, 1, 32'h0100_0004, 1, 0, 32'h0100_0000, 0, 0, 0, 0);
        // Accept an I fetch, reset, and contention must go back to I.
        step(0, 1, 32'h0100_0004, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 32'h0100_0030, 1, 0, 32'h0100_0034, 0, 0, 0, 0);
        step(0, 1, 32'h0100_0030, 1, 0, 32'h0100_0034, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 32'h0100_0034, 0, 2, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
